// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between the CPU load/store port
// and an external requester, with req/ack handshakes and fixed read latency.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  state_e              state_q;
  logic                owner_q;
  logic                we_q;
  logic [1:0]          lat_q;
  logic                cpu_ack_q;
  logic                ext_ack_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   ext_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                gnt_any;
  logic                gnt_ext;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // On a conflict the port that did not own the last transaction wins.
  assign gnt_any   = cpu_req | ext_req;
  assign gnt_ext   = ext_req & (~cpu_req | ~owner_q);
  assign sel_we    = gnt_ext ? ext_we    : cpu_we;
  assign sel_addr  = gnt_ext ? ext_addr  : cpu_addr;
  assign sel_wdata = gnt_ext ? ext_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      lat_q       <= 2'd0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // RAM strobes and acks are single-cycle pulses unless re-asserted below.
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            owner_q     <= gnt_ext;
            we_q        <= sel_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (we_q) begin
            cpu_ack_q <= ~owner_q;
            ext_ack_q <= owner_q;
            state_q   <= StResp;
          end else begin
            lat_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (lat_q == 2'd0) begin
            if (owner_q) ext_rdata_q <= mem_rdata;
            else         cpu_rdata_q <= mem_rdata;
            cpu_ack_q <= ~owner_q;
            ext_ack_q <= owner_q;
            state_q   <= StResp;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store port and an external requester (program loader or peripheral DMA).
- Uses a per-port req/ack handshake, round-robin arbitration and a fixed-latency RAM interface.
- Generates a stall for the CPU while its access is pending.
- Sits between the CPU MemWrite/ALUResult/WriteData/ReadData signals and the data RAM.

Parameters:
- ADDR_W, 32, address width for both ports and the RAM.
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in cycles. Legal range is 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low. The clock is clk. The reset is asynchronous and active-low (rst=0 resets).
- cpu_req  in  1  CPU access request. Held high until cpu_ack.
- cpu_we  in  1  1=store, 0=load. Held stable while cpu_req=1.
- cpu_addr  in  ADDR_W  CPU address (ALUResult).
- cpu_wdata  in  DATA_W  CPU store data (WriteData).
- cpu_rdata  out  DATA_W  CPU load data (ReadData), registered.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack.
- ext_req, ext_we, ext_addr, ext_wdata, ext_rdata, ext_ack: same as the cpu_* ports, for the external port.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data. Valid RD_LAT cycles after the mem_en cycle.
- busy  out  1  state != IDLE.
- owner  out  1  current or last owner: 0=CPU, 1=EXT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All mem_* outputs = 0.
  - cpu_ack = ext_ack = 0; cpu_rdata = ext_rdata = 0; busy = 0.
  - owner = 1, so the CPU wins the first conflict.
  - lat_cnt = 0.
- IDLE:
  - Samples both req lines.
  - None asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted: grant the port != owner (round-robin).
  - On grant: latch owner, we, addr and wdata from the granted port; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched fields.
  - Write: next state is RESP.
  - Read: next state is WAIT with lat_cnt = RD_LAT-1.
- WAIT:
  - mem_en=0.
  - If lat_cnt == 0: capture mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise decrement lat_cnt.
  - Net effect: mem_rdata is sampled at the end of cycle ACCESS+RD_LAT.
- RESP (1 cycle): owner's ack=1, then go to IDLE.
- Requester rules:
  - The requester drops req, or presents a new request, after seeing ack.
  - The IDLE cycle after RESP re-arbitrates.
  - A req still high in that IDLE cycle is treated as a new request.
- Latency from the IDLE sample cycle T:
  - Write: ack at T+2.
  - Read: ack at T+2+RD_LAT.
  - Minimum spacing between grants: write 3 cycles, read 3+RD_LAT cycles.
- mem_* hold:
  - mem_we, mem_addr and mem_wdata are driven only while mem_en=1; otherwise 0.
  - The RAM sees no writes outside ACCESS.
- The non-owner port's rdata is unchanged by a transaction. Write transactions never modify any rdata register.
- Req dropped by a requester mid-transaction: the transaction still completes and ack still pulses. There is no cancellation.
- Changing a request's fields while its req is high has no effect once it has been granted (fields are latched).
- A request arriving while busy waits in IDLE for the next arbitration. No request is ever lost while its req stays high.
- Fairness: with both ports continuously requesting, grants strictly alternate CPU, EXT, CPU, ...
- Reset mid-transaction:
  - Immediate return to IDLE; mem_en falls asynchronously.
  - No ack is issued for the aborted access.
  - A still-pending req is re-arbitrated in the first cycle after rst rises. The CPU wins if both are pending.
- No address alignment checks; addresses pass through unchanged.

Test Plan:
- Reset: hold rst=0 with both reqs high → all outputs 0, owner=1. Release rst → first grant goes to the CPU.
- CPU store: cpu_req=1, cpu_we=1, addr=0x00001000, wdata=4 sampled at T → mem_en=1, mem_we=1, mem_addr=0x1000, mem_wdata=4 at T+1 only; cpu_ack at T+2; cpu_stall high T..T+1.
- CPU load with RD_LAT=2, RAM returns 0xDEADBEEF at T+3 → cpu_ack and cpu_rdata=0xDEADBEEF at T+4; ext_rdata unchanged.
- Simultaneous continuous writes from both ports, 6 transactions → owner sequence 0,1,0,1,0,1; each ack 3 cycles apart; ack never asserted to both ports in the same cycle.
- EXT read in progress with RD_LAT=4 while cpu_req rises at ACCESS+1 → CPU is granted in the IDLE cycle right after ext_ack; cpu_stall stays high throughout.
- rst asserted during WAIT of an EXT read → mem_en=0 immediately, no ext_ack. With cpu_req and ext_req held, after release: CPU is granted first, then EXT.
